// File: rtl/cbist_if.sv
// cbist_if: BIST pin/datapath bundle between the top level and the circular-BIST controller.
interface cbist_if #(
  parameter int SIG_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 bist_start;
  logic [SIG_WIDTH-1:0] signature_in;
  logic                 bist_mode;
  logic                 bist_init;
  logic                 bist_hold;
  logic                 bist_end;
  logic                 pass_fail;
  logic [SIG_WIDTH-1:0] signature_out;
  logic [CNT_WIDTH-1:0] cycle_count;
  modport master (
    output bist_start, signature_in,
    input  bist_mode, bist_init, bist_hold, bist_end, pass_fail, signature_out, cycle_count
  );
  modport slave (
    input  bist_start, signature_in,
    output bist_mode, bist_init, bist_hold, bist_end, pass_fail, signature_out, cycle_count
  );
endinterface

// File: rtl/cbist_controller.sv
// cbist_controller: sequences init, compaction, signature capture and golden compare for circular BIST.
module cbist_controller #(
  parameter int                   SIG_WIDTH   = 16,
  parameter int                   CNT_WIDTH   = 16,
  parameter int                   TEST_CYCLES = 1000,
  parameter int                   INIT_CYCLES = 2,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG  = '0
) (
  input logic  clock,
  input logic  reset,
  cbist_if.slave bus
);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, INIT, RUN, COMPARE, DONE} state_t;
  state_t         state, state_nx;
  logic           start_d;
  logic           start_rise;
  logic [IW-1:0]  init_cnt;
  logic           init_last;
  logic           run_last;
  assign start_rise = bus.bist_start & ~start_d;
  assign init_last  = init_cnt == IW'(INIT_CYCLES - 1);
  assign run_last   = bus.cycle_count == CNT_WIDTH'(TEST_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_rise ? INIT : IDLE;
      INIT:    state_nx = init_last ? RUN : INIT;
      RUN:     state_nx = run_last ? COMPARE : RUN;
      COMPARE: state_nx = DONE;
      DONE:    state_nx = start_rise ? INIT : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Controls decode straight from the state register, so no input reaches an output combinationally.
  always_comb begin
    bus.bist_mode = (state == INIT) || (state == RUN) || (state == COMPARE);
    bus.bist_init = state == INIT;
    bus.bist_hold = state == COMPARE;
    bus.bist_end  = state == DONE;
  end
  // start_d resets high so a start held across reset release is not taken as an edge.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      start_d           <= 1'b1;
      init_cnt          <= '0;
      bus.cycle_count   <= '0;
      bus.pass_fail     <= 1'b0;
      bus.signature_out <= '0;
    end else begin
      start_d  <= bus.bist_start;
      init_cnt <= (state == INIT && !init_last) ? init_cnt + 1'b1 : '0;
      if (state_nx == INIT)
        bus.cycle_count <= '0;
      else if (state == RUN && !run_last)
        bus.cycle_count <= bus.cycle_count + 1'b1;
      if (state == COMPARE) begin
        bus.signature_out <= bus.signature_in;
        bus.pass_fail     <= bus.signature_in == GOLDEN_SIG;
      end else if (state_nx == INIT)
        bus.pass_fail <= 1'b0;
    end
endmodule

// File: tb/tb_cbist_controller.sv
// tb_cbist_controller: directed stimulus with a scoreboard monitor checking each completed test.
module tb_cbist_controller;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int TC = 8;
  localparam int IC = 2;
  localparam logic [SW-1:0] GOLD = 16'hA5C3;
  localparam int LAT = IC + TC + 1;
  typedef struct {
    int          exp_cyc;
    logic        pf;
    logic [SW-1:0] sig;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  cbist_if #(.SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();
  cbist_controller #(
    .SIG_WIDTH(SW), .CNT_WIDTH(CW), .TEST_CYCLES(TC), .INIT_CYCLES(IC), .GOLDEN_SIG(GOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, " mode"}, 32'(bus.bist_mode), 0);
    check({tag, " init"}, 32'(bus.bist_init), 0);
    check({tag, " hold"}, 32'(bus.bist_hold), 0);
    check({tag, " end"}, 32'(bus.bist_end), 0);
    check({tag, " pass_fail"}, 32'(bus.pass_fail), 0);
    check({tag, " sig_out"}, 32'(bus.signature_out), 0);
    check({tag, " cycle_count"}, 32'(bus.cycle_count), 0);
  endtask
  task automatic start_test(input logic [SW-1:0] sig, input logic pf);
    exp_t e;
    bus.signature_in = sig;
    bus.bist_start = 1'b1;
    e.exp_cyc = cyc + 1 + LAT;
    e.pf = pf;
    e.sig = sig;
    sb.push_back(e);
    tick();
    check("start end_cleared", 32'(bus.bist_end), 0);
    check("start pf_cleared", 32'(bus.pass_fail), 0);
    check("start init_on", 32'(bus.bist_init), 1);
    tick();
    bus.bist_start = 1'b0;
  endtask
  task automatic wait_end();
    int n = 0;
    while (!bus.bist_end && n < 40) begin
      tick();
      n++;
    end
    if (!bus.bist_end) check("bist_end timeout", 0, 1);
    tick();
  endtask
  // Monitor: tallies control pulse widths and scores each bist_end rise against the queue.
  int   n_mode = 0, n_init = 0, n_hold = 0;
  logic prev_end = 1'b0;
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    #1;
    if (reset) begin
      n_mode = 0;
      n_init = 0;
      n_hold = 0;
      prev_end = 1'b0;
    end else begin
      n_mode += int'(bus.bist_mode);
      n_init += int'(bus.bist_init);
      n_hold += int'(bus.bist_hold);
      if (bus.bist_end && !prev_end) begin
        if (sb.size() == 0) check("unexpected bist_end", 1, 0);
        else begin
          e = sb.pop_front();
          check("end latency", cyc, e.exp_cyc);
          check("pass_fail", 32'(bus.pass_fail), 32'(e.pf));
          check("signature_out", 32'(bus.signature_out), 32'(e.sig));
          check("mode cycles", n_mode, LAT);
          check("init cycles", n_init, IC);
          check("hold cycles", n_hold, 1);
          check("cycle_count final", 32'(bus.cycle_count), TC - 1);
        end
        n_mode = 0;
        n_init = 0;
        n_hold = 0;
      end
      prev_end = bus.bist_end;
    end
  end
  initial begin
    bus.bist_start = 1'b1;
    bus.signature_in = '0;
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held start mode", 32'(bus.bist_mode), 0);
    check("held start init", 32'(bus.bist_init), 0);
    bus.bist_start = 1'b0;
    tick();
    start_test(16'hA5C3, 1'b1);
    wait_end();
    start_test(16'hA5C2, 1'b0);
    wait_end();
    bus.signature_in = 16'hFFFF;
    repeat (3) tick();
    check("sig_out held", 32'(bus.signature_out), 32'h0000A5C2);
    check("end held", 32'(bus.bist_end), 1);
    start_test(16'hA5C3, 1'b1);
    repeat (4) tick();
    check("retrig count3", 32'(bus.cycle_count), 3);
    bus.bist_start = 1'b1;
    for (int k = 4; k < TC; k++) begin
      tick();
      check("retrig count", 32'(bus.cycle_count), k);
    end
    bus.bist_start = 1'b0;
    wait_end();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_all_zero("async reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    start_test(16'h1234, 1'b0);
    repeat (6) tick();
    check("run count5", 32'(bus.cycle_count), 5);
    #2 reset = 1'b1;
    void'(sb.pop_back());
    #1;
    check("midrun mode", 32'(bus.bist_mode), 0);
    check("midrun count", 32'(bus.cycle_count), 0);
    check("midrun end", 32'(bus.bist_end), 0);
    tick();
    reset = 1'b0;
    tick();
    start_test(16'hA5C3, 1'b1);
    wait_end();
    check("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cbist_controller.md
Name: cbist_controller

Overview:
- Sequencing controller for the circular-BIST wrapper around the 4-requester arbiter.
- On a start request it puts the circular register into test mode, initialises it, then runs a fixed number of compaction cycles.
- It freezes the register, captures the signature, compares it against a golden constant, and reports bist_end and pass_fail.
- It sits between the top-level BIST pins and the circular register/arbiter datapath.

Parameters:
SIG_WIDTH, 16, width of the circular register signature.
CNT_WIDTH, 16, width of the cycle counter; must satisfy 2^CNT_WIDTH > TEST_CYCLES.
TEST_CYCLES, 1000, number of compaction clock cycles in RUN (>=1).
INIT_CYCLES, 2, number of cycles bist_init is held in INIT (>=1).
GOLDEN_SIG, 16'h0000, expected fault-free signature.

Ports:
clock  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
bist_start  in  1  level input; only a rising edge starts a test.
signature_in  in  SIG_WIDTH  current contents of the circular register.
bist_mode  out  1  1 = circular register and arbiter in test configuration.
bist_init  out  1  1 = load seed / clear circular register.
bist_hold  out  1  1 = freeze circular register.
bist_end  out  1  test complete, result valid.
pass_fail  out  1  1 = signature matched GOLDEN_SIG; valid only while bist_end=1.
signature_out  out  SIG_WIDTH  signature captured at COMPARE.
cycle_count  out  CNT_WIDTH  current RUN cycle index, for debug.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- On reset:
  - state=IDLE.
  - All outputs are 0: bist_mode, bist_init, bist_hold, bist_end, pass_fail, signature_out and cycle_count.
  - The internal start_d register resets to 1, so a bist_start held high across reset deassertion is not a start.
- Edge detect: start_rise = bist_start & ~start_d. start_d <= bist_start every cycle.
- All outputs are registered, i.e. decoded from state and counters. There is no combinational input-to-output path.
- IDLE:
  - All control outputs are 0.
  - start_rise -> INIT on the same clock edge.
- INIT:
  - bist_mode=1, bist_init=1.
  - The init counter runs 0..INIT_CYCLES-1.
  - cycle_count is held at 0.
  - On the last init count -> RUN.
- RUN:
  - bist_mode=1, bist_init=0, bist_hold=0.
  - cycle_count increments once per cycle, 0..TEST_CYCLES-1.
  - When cycle_count==TEST_CYCLES-1 -> COMPARE.
- COMPARE (1 cycle):
  - bist_mode=1, bist_hold=1.
  - signature_out <= signature_in.
  - pass_fail <= (signature_in==GOLDEN_SIG).
  - -> DONE.
- DONE:
  - bist_end=1, bist_mode=0, bist_hold=0.
  - signature_out, pass_fail and cycle_count are held.
  - Remains in DONE indefinitely.
  - start_rise -> INIT. bist_end, pass_fail and cycle_count clear at that edge; signature_out holds until the next COMPARE.
- Latency:
  - The first INIT cycle follows the edge that samples start_rise.
  - bist_end rises exactly INIT_CYCLES+TEST_CYCLES+1 cycles after that edge.
- bist_start activity in INIT, RUN or COMPARE is ignored. This includes new rising edges; no restart and no queuing.
- A bist_start held high for several cycles produces exactly one test.
- Reset asserted in any state returns immediately to IDLE with reset values. A partial signature is discarded.
- signature_in changes outside COMPARE have no effect on the outputs.
- cycle_count never wraps: counting stops at TEST_CYCLES-1.

Test Plan:
- Common setup: TEST_CYCLES=8, INIT_CYCLES=2, GOLDEN_SIG=16'hA5C3.
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, before the next clock edge. Release with bist_start=1 -> stays IDLE, bist_mode=0.
- Pass run: rising edge on bist_start, held 2 cycles; signature_in=16'hA5C3 during COMPARE -> bist_init=1 for 2 cycles, bist_mode=1 for 11 cycles, bist_hold=1 for 1 cycle. bist_end=1 exactly 11 cycles after the start edge, with pass_fail=1 and signature_out=16'hA5C3.
- Fail run: same as the pass run but signature_in=16'hA5C2 -> bist_end=1, pass_fail=0, signature_out=16'hA5C2.
- Retrigger ignored: toggle bist_start 0->1 at RUN cycle 3 -> cycle_count continues 4,5,6,7 and bist_end still rises at cycle 11.
- Restart from DONE: new rising edge -> bist_end=0 and pass_fail=0 next cycle, bist_init=1 for 2 cycles. Change signature_in to 16'hFFFF after COMPARE -> signature_out stays at the captured value.
- Reset mid-RUN: assert reset at cycle_count=5 -> state IDLE, bist_mode=0, cycle_count=0, bist_end=0. A fresh start edge after reset completes normally in 11 cycles.
